player_input: RTL and testbench



---
 rtl/player_input.sv | 167 ++++++++++++++++
 tb/tb_player_input.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input.sv
// player_input: registered conditioner between hps_io and Main.
// It merges PS/2 key state with the MiSTer joystick words into two player
// bundles plus service buttons. It cancels opposing directions when asked,
// and turns each coin press into one fixed-width coin pulse.
//
// Coin FSM (one per player):
//   state    | meaning
//   ST_IDLE  | waiting for a rising edge on the raw coin signal
//   ST_PULSE | coin output high, counter running down to 0
//   ST_HOLD  | pulse done, coin still held; wait for release
module player_input #(
    parameter int COIN_CYCLES = 1600000,
    parameter int CNT_W       = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] ps2_key,
    input  logic [31:0] joystick_0,
    input  logic [31:0] joystick_1,
    input  logic        socd_en,
    output logic [9:0]  player1,
    output logic [9:0]  player2,
    output logic [1:0]  service
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_CYCLES - 1);

    // Key register bit positions.
    // 0 up1, 1 down1, 2 left1, 3 right1, 4 b1_1, 5 b2_1, 6 b3_1, 7 start1,
    // 8 coin1, 9 pause1, 10 start2, 11 coin2, 12 service1, 13 service2,
    // 14 up2, 15 down2, 16 left2, 17 right2, 18 b1_2, 19 b2_2, 20 b3_2
    logic        old_toggle;
    logic [20:0] keys;
    logic        key_hit;
    logic [4:0]  key_idx;

    logic [9:0]  raw1;
    logic [9:0]  raw2;
    logic [1:0]  raw_svc;
    logic [3:0]  dir1;
    logic [3:0]  dir2;
    logic [1:0]  coin_raw;

    logic [1:0][1:0]       coin_state;
    logic [1:0][CNT_W-1:0] coin_cnt;
    logic [1:0]            coin_prev;

    // Extended-key flag and the upper joystick bits are not used.
    logic unused;
    assign unused = ^{ps2_key[8], joystick_0[31:11], joystick_1[31:11]};

    // Scancode to key register index.
    always_comb begin
        key_hit = 1'b1;
        key_idx = 5'd0;
        case (ps2_key[7:0])
            8'h75:   key_idx = 5'd0;
            8'h72:   key_idx = 5'd1;
            8'h6B:   key_idx = 5'd2;
            8'h74:   key_idx = 5'd3;
            8'h14:   key_idx = 5'd4;
            8'h11:   key_idx = 5'd5;
            8'h29:   key_idx = 5'd6;
            8'h16:   key_idx = 5'd7;
            8'h2E:   key_idx = 5'd8;
            8'h4D:   key_idx = 5'd9;
            8'h1E:   key_idx = 5'd10;
            8'h36:   key_idx = 5'd11;
            8'h46:   key_idx = 5'd12;
            8'h45:   key_idx = 5'd13;
            8'h2D:   key_idx = 5'd14;
            8'h2B:   key_idx = 5'd15;
            8'h23:   key_idx = 5'd16;
            8'h34:   key_idx = 5'd17;
            8'h1C:   key_idx = 5'd18;
            8'h1B:   key_idx = 5'd19;
            8'h15:   key_idx = 5'd20;
            default: key_hit = 1'b0;
        endcase
    end

    // Keyboard tracker. Reset loads the current toggle, so reset itself never looks like an event.
    always_ff @(posedge clk) begin
        old_toggle <= ps2_key[10];
        if (rst) begin
            keys <= '0;
        end else if ((ps2_key[10] != old_toggle) && key_hit) begin
            keys[key_idx] <= ps2_key[9];
        end
    end

    // Raw signals in output order: {pause, coin, start, b3, b2, b1, right, left, down, up}.
    assign raw1 = {joystick_0[9] | keys[9],  joystick_0[8] | keys[8],
                   joystick_0[7] | keys[7],  joystick_0[6] | keys[6],
                   joystick_0[5] | keys[5],  joystick_0[4] | keys[4],
                   joystick_0[0] | keys[3],  joystick_0[1] | keys[2],
                   joystick_0[2] | keys[1],  joystick_0[3] | keys[0]};
    assign raw2 = {joystick_1[9],            joystick_1[8] | keys[11],
                   joystick_1[7] | keys[10], joystick_1[6] | keys[20],
                   joystick_1[5] | keys[19], joystick_1[4] | keys[18],
                   joystick_1[0] | keys[17], joystick_1[1] | keys[16],
                   joystick_1[2] | keys[15], joystick_1[3] | keys[14]};
    assign raw_svc  = {joystick_1[10] | keys[13], joystick_0[10] | keys[12]};
    assign coin_raw = {raw2[8], raw1[8]};

    // dirs = {right, left, down, up}
    function automatic logic [3:0] socd_clean(input logic [3:0] dirs, input logic en);
        logic [3:0] d;
        d = dirs;
        if (en && dirs[0] && dirs[1]) d[1:0] = 2'b00;
        if (en && dirs[2] && dirs[3]) d[3:2] = 2'b00;
        return d;
    endfunction

    assign dir1 = socd_clean(raw1[3:0], socd_en);
    assign dir2 = socd_clean(raw2[3:0], socd_en);

    // Coin pulse FSMs. coin_prev resets high, so a coin held through reset must be released before it counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            coin_state <= {ST_IDLE, ST_IDLE};
            coin_cnt   <= '0;
            coin_prev  <= 2'b11;
        end else begin
            coin_prev <= coin_raw;
            for (int p = 0; p < 2; p++) begin
                case (coin_state[p])
                    ST_IDLE: begin
                        if (coin_raw[p] && !coin_prev[p]) begin
                            coin_state[p] <= ST_PULSE;
                            coin_cnt[p]   <= CNT_LOAD;
                        end
                    end
                    ST_PULSE: begin
                        if (coin_cnt[p] == '0) begin
                            coin_state[p] <= coin_raw[p] ? ST_HOLD : ST_IDLE;
                        end else begin
                            coin_cnt[p] <= coin_cnt[p] - CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (!coin_raw[p]) coin_state[p] <= ST_IDLE;
                    end
                    default: coin_state[p] <= ST_IDLE;
                endcase
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            player1 <= '0;
            player2 <= '0;
            service <= '0;
        end else begin
            player1 <= {raw1[9], coin_state[0] == ST_PULSE, raw1[7:4], dir1};
            player2 <= {raw2[9], coin_state[1] == ST_PULSE, raw2[7:4], dir2};
            service <= raw_svc;
        end
    end

endmodule

// File: tb/tb_player_input.sv
// tb_player_input: directed scenarios plus randomized traffic checked against
// a behavioural model of the player input conditioner.
module tb_player_input;

    localparam int C = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] ps2_key;
    logic [31:0] joystick_0;
    logic [31:0] joystick_1;
    logic        socd_en;
    logic [9:0]  player1;
    logic [9:0]  player2;
    logic [1:0]  service;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    player_input #(.COIN_CYCLES(C), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .socd_en    (socd_en),
        .player1    (player1),
        .player2    (player2),
        .service    (service)
    );

    // ---------------- reference model ----------------
    bit         kst [256];      // pressed state per scancode
    bit         old_t;
    int         pulse_left [2]; // coin clocks still to be output
    bit  [1:0]  cprev;
    logic [9:0] exp_p1  = '0;
    logic [9:0] exp_p2  = '0;
    logic [1:0] exp_svc = '0;
    logic [9:0] r1, r2;
    bit         craw;

    function automatic logic [9:0] clean(input logic [9:0] r, input logic en);
        logic [9:0] v;
        v = r;
        if (en && r[0] && r[1]) begin v[0] = 1'b0; v[1] = 1'b0; end
        if (en && r[2] && r[3]) begin v[2] = 1'b0; v[3] = 1'b0; end
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (kst[i]) kst[i] = 1'b0;
            old_t = ps2_key[10];
            pulse_left[0] = 0;
            pulse_left[1] = 0;
            cprev   = 2'b11;
            exp_p1  = '0;
            exp_p2  = '0;
            exp_svc = '0;
        end else begin
            r1 = {joystick_0[9] | kst[8'h4D], joystick_0[8] | kst[8'h2E],
                  joystick_0[7] | kst[8'h16], joystick_0[6] | kst[8'h29],
                  joystick_0[5] | kst[8'h11], joystick_0[4] | kst[8'h14],
                  joystick_0[0] | kst[8'h74], joystick_0[1] | kst[8'h6B],
                  joystick_0[2] | kst[8'h72], joystick_0[3] | kst[8'h75]};
            r2 = {joystick_1[9],              joystick_1[8] | kst[8'h36],
                  joystick_1[7] | kst[8'h1E], joystick_1[6] | kst[8'h15],
                  joystick_1[5] | kst[8'h1B], joystick_1[4] | kst[8'h1C],
                  joystick_1[0] | kst[8'h34], joystick_1[1] | kst[8'h23],
                  joystick_1[2] | kst[8'h2B], joystick_1[3] | kst[8'h2D]};
            exp_p1 = clean(r1, socd_en);
            exp_p1[8] = (pulse_left[0] > 0);
            exp_p2 = clean(r2, socd_en);
            exp_p2[8] = (pulse_left[1] > 0);
            exp_svc = {joystick_1[10] | kst[8'h45], joystick_0[10] | kst[8'h46]};
            for (int p = 0; p < 2; p++) begin
                craw = (p == 0) ? r1[8] : r2[8];
                if (pulse_left[p] > 0) pulse_left[p] = pulse_left[p] - 1;
                else if (craw && !cprev[p]) pulse_left[p] = C;
                cprev[p] = craw;
            end
            if (ps2_key[10] != old_t) kst[ps2_key[7:0]] = ps2_key[9];
            old_t = ps2_key[10];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic kb(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int hi;
        rst = 1'b1; ps2_key = '0; joystick_0 = 32'h100; joystick_1 = '0; socd_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            nvec++;
            if ({player1, player2, service} !== 22'd0) begin
                nmis++;
                $display("FAIL reset_outputs: got %h required 0", {player1, player2, service});
            end
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            nvec++;
            if (player1[8] !== 1'b0) begin
                nmis++;
                $display("FAIL held_coin_after_reset: got %b required 0", player1[8]);
            end
        end
        joystick_0 = '0;
        repeat (2) @(negedge clk);
        hi = 0;
        joystick_0[8] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) joystick_0[8] = 1'b0;
            @(negedge clk);
            if (player1[8] === 1'b1) hi++;
            nvec++;
            if (player1 !== exp_p1) begin
                nmis++;
                $display("FAIL reset_coin_model: got %h required %h", player1, exp_p1);
            end
        end
        nvec++;
        if (hi != C) begin
            nmis++;
            $display("FAIL coin_width_after_reset: got %0d required %0d", hi, C);
        end
    endtask

    task automatic test_keyboard();
        kb(8'h75, 1'b1);
        @(negedge clk);
        nvec++;
        if (player1[0] !== 1'b0) begin
            nmis++; $display("FAIL kb_latency_early: got %b required 0", player1[0]);
        end
        @(negedge clk);
        nvec++;
        if (player1[0] !== 1'b1) begin
            nmis++; $display("FAIL kb_up1_press: got %b required 1", player1[0]);
        end
        kb(8'h75, 1'b0);
        repeat (2) @(negedge clk);
        nvec++;
        if (player1[0] !== 1'b0) begin
            nmis++; $display("FAIL kb_up1_release: got %b required 0", player1[0]);
        end
        kb(8'h99, 1'b1);
        repeat (3) @(negedge clk);
        nvec++;
        if ({player1, player2, service} !== 22'd0) begin
            nmis++; $display("FAIL kb_unknown_code: got %h required 0", {player1, player2, service});
        end
    endtask

    task automatic test_socd();
        joystick_0 = 32'h3; joystick_1 = 32'hC; socd_en = 1'b1;
        @(negedge clk);
        nvec++;
        if (player2[1:0] !== 2'b00 || player1[3:2] !== 2'b00) begin
            nmis++; $display("FAIL socd_on: got p2=%b p1=%b required 00 00", player2[1:0], player1[3:2]);
        end
        socd_en = 1'b0;
        @(negedge clk);
        nvec++;
        if (player2[1:0] !== 2'b11 || player1[3:2] !== 2'b11) begin
            nmis++; $display("FAIL socd_off: got p2=%b p1=%b required 11 11", player2[1:0], player1[3:2]);
        end
        joystick_0 = 32'h4; joystick_1 = '0; socd_en = 1'b1;
        kb(8'h75, 1'b1);
        repeat (2) @(negedge clk);
        nvec++;
        if (player1[1:0] !== 2'b00) begin
            nmis++; $display("FAIL socd_mixed_on: got %b required 00", player1[1:0]);
        end
        socd_en = 1'b0;
        @(negedge clk);
        nvec++;
        if (player1[1:0] !== 2'b11) begin
            nmis++; $display("FAIL socd_mixed_off: got %b required 11", player1[1:0]);
        end
        kb(8'h75, 1'b0); joystick_0 = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_coin_hold();
        int hi, pulses;
        logic prevb;
        for (int s = 0; s < 3; s++) begin
            hi = 0; pulses = 0; prevb = 1'b0;
            joystick_1[8] = 1'b1;
            for (int i = 0; i < 32; i++) begin
                if (s == 0 && i == 20) joystick_1[8] = 1'b0;
                if (s == 1 && (i == 2 || i == 6)) joystick_1[8] = 1'b0;
                if (s == 1 && i == 4) joystick_1[8] = 1'b1;
                if (s == 2 && i == 3) joystick_1[8] = 1'b0;
                @(negedge clk);
                if (player2[8] === 1'b1) hi++;
                if (player2[8] === 1'b1 && !prevb) pulses++;
                prevb = player2[8];
            end
            nvec++;
            if (hi != C || pulses != 1) begin
                nmis++;
                $display("FAIL coin_pulse_s%0d: got %0d clocks in %0d pulses required %0d in 1", s, hi, pulses, C);
            end
        end
    endtask

    task automatic test_rst_mid_pulse();
        int seen, hi;
        seen = 0;
        joystick_0[8] = 1'b1;
        for (int i = 0; i < 12 && seen < 3; i++) begin
            @(negedge clk);
            if (player1[8] === 1'b1) seen++;
        end
        nvec++;
        if (seen < 3) begin
            nmis++; $display("FAIL rst_mid_wait: got %0d pulse clocks required 3", seen);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            nvec++;
            if ({player1, player2, service} !== 22'd0) begin
                nmis++; $display("FAIL rst_mid_outputs: got %h required 0", {player1, player2, service});
            end
        end
        rst = 1'b0;
        hi = 0;
        repeat (12) begin
            @(negedge clk);
            if (player1[8] === 1'b1) hi++;
        end
        nvec++;
        if (hi != 0) begin
            nmis++; $display("FAIL rst_held_coin: got %0d pulse clocks required 0", hi);
        end
        joystick_0 = '0;
        @(negedge clk);
    endtask

    task automatic test_service();
        kb(8'h46, 1'b1); joystick_1[10] = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if (service !== 2'b11) begin
            nmis++; $display("FAIL service_both: got %b required 11", service);
        end
        kb(8'h46, 1'b0);
        repeat (2) @(negedge clk);
        nvec++;
        if (service !== 2'b10) begin
            nmis++; $display("FAIL service_key_release: got %b required 10", service);
        end
        joystick_1 = '0;
        @(negedge clk);
        nvec++;
        if (service !== 2'b00) begin
            nmis++; $display("FAIL service_clear: got %b required 00", service);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [6];
        logic       prs   [6];
        codes = '{8'h14, 8'h1C, 8'h75, 8'h14, 8'h1C, 8'h75};
        prs   = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        for (int i = 0; i < 9; i++) begin
            if (i < 4) kb(codes[i], prs[i]);
            @(negedge clk);
            nvec++;
            if (player1 !== exp_p1 || player2 !== exp_p2) begin
                nmis++; $display("FAIL b2b_model_%0d: got %h %h required %h %h", i, player1, player2, exp_p1, exp_p2);
            end
        end
        nvec++;
        if (player1[4] !== 1'b0 || player2[4] !== 1'b1 || player1[0] !== 1'b1) begin
            nmis++; $display("FAIL b2b_final: got b1_1=%b b1_2=%b up1=%b required 0 1 1", player1[4], player2[4], player1[0]);
        end
        kb(codes[4], prs[4]); @(negedge clk);
        kb(codes[5], prs[5]); repeat (2) @(negedge clk);
        nvec++;
        if ({player1, player2, service} !== 22'd0) begin
            nmis++; $display("FAIL b2b_release: got %h required 0", {player1, player2, service});
        end
    endtask

    task automatic test_random();
        logic [7:0] keyset [21];
        logic [7:0] code;
        keyset = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h1E, 8'h2E, 8'h36,
                   8'h46, 8'h45, 8'h4D, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15};
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 2) == 0) begin
                code = ($urandom_range(0, 4) == 0) ? 8'($urandom) : keyset[$urandom_range(0, 20)];
                kb(code, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) joystick_0 = $urandom;
            if ($urandom_range(0, 3) == 0) joystick_1 = $urandom;
            if ($urandom_range(0, 15) == 0) socd_en = ~socd_en;
            @(negedge clk);
            nvec++;
            if (player1 !== exp_p1 || player2 !== exp_p2 || service !== exp_svc) begin
                nmis++;
                $display("FAIL random_%0d: got %h %h %b required %h %h %b",
                         i, player1, player2, service, exp_p1, exp_p2, exp_svc);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_keyboard();
        test_socd();
        test_coin_hold();
        test_rst_mid_pulse();
        test_service();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
